// File: rtl/lemmings_pkg.sv
// Shared types for the lemming array: channel state encoding, counter width, flag decode.
package lemmings_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [3:0] {
    WL    = 4'd0,
    WR    = 4'd1,
    FALLL = 4'd2,
    FALLR = 4'd3,
    DIGL  = 4'd4,
    DIGR  = 4'd5,
    BLKL  = 4'd6,
    BLKR  = 4'd7,
    DEAD  = 4'd8
  } state_t;

  typedef struct packed {
    logic walk_left;
    logic walk_right;
    logic aaah;
    logic digging;
    logic blocking;
    logic dead;
  } lem_out_t;

  // One-hot flag set for a state; unused codes decode to all zeros.
  function automatic lem_out_t decode_state(input state_t s);
    lem_out_t o;
    o            = '0;
    o.walk_left  = (s == WL);
    o.walk_right = (s == WR);
    o.aaah       = (s == FALLL) || (s == FALLR);
    o.digging    = (s == DIGL)  || (s == DIGR);
    o.blocking   = (s == BLKL)  || (s == BLKR);
    o.dead       = (s == DEAD);
    return o;
  endfunction

endpackage

// File: rtl/lemming_fsm.sv
// One lemming channel: state register, fall/dig counters and registered flag outputs.
module lemming_fsm
  import lemmings_pkg::*;
#(
  parameter int unsigned FALL_LIMIT = 20,
  parameter int unsigned DIG_MAX    = 0
) (
  input  logic clk,
  input  logic areset,
  input  logic i_bump_left,
  input  logic i_bump_right,
  input  logic i_ground,
  input  logic i_dig,
  input  logic i_block,
  output logic o_walk_left,
  output logic o_walk_right,
  output logic o_aaah,
  output logic o_digging,
  output logic o_blocking,
  output logic o_dead
);

  localparam logic [CNT_W-1:0] FALL_SAT    = CNT_W'(FALL_LIMIT);
  localparam bit               DIG_LIMITED = (DIG_MAX != 0);
  localparam logic [CNT_W-1:0] DIG_LAST    = CNT_W'(DIG_LIMITED ? DIG_MAX - 1 : 32'd0);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_fall_cnt;
  logic [CNT_W-1:0] r_dig_cnt;
  logic [CNT_W-1:0] w_fall_cnt_nxt;
  logic [CNT_W-1:0] w_dig_cnt_nxt;
  lem_out_t         r_out;
  logic             w_fall_fatal;
  logic             w_dig_done;

  assign w_fall_fatal = (r_fall_cnt >= FALL_SAT);
  assign w_dig_done   = DIG_LIMITED && (r_dig_cnt == DIG_LAST);

  // Next state with ground loss > dig > block > bump priority; counters run only while staying put.
  always_comb begin
    w_next         = r_state;
    w_fall_cnt_nxt = '0;
    w_dig_cnt_nxt  = '0;
    case (r_state)
      WL: begin
        if (!i_ground)         w_next = FALLL;
        else if (i_dig)        w_next = DIGL;
        else if (i_block)      w_next = BLKL;
        else if (i_bump_left)  w_next = WR;
      end
      WR: begin
        if (!i_ground)         w_next = FALLR;
        else if (i_dig)        w_next = DIGR;
        else if (i_block)      w_next = BLKR;
        else if (i_bump_right) w_next = WL;
      end
      FALLL: if (i_ground) w_next = w_fall_fatal ? DEAD : WL;
      FALLR: if (i_ground) w_next = w_fall_fatal ? DEAD : WR;
      DIGL: begin
        if (!i_ground)       w_next = FALLL;
        else if (w_dig_done) w_next = WL;
      end
      DIGR: begin
        if (!i_ground)       w_next = FALLR;
        else if (w_dig_done) w_next = WR;
      end
      BLKL: if (!i_ground) w_next = FALLL;
      BLKR: if (!i_ground) w_next = FALLR;
      DEAD: w_next = DEAD;
      default: w_next = WL;
    endcase

    if ((r_state == FALLL || r_state == FALLR) && (w_next == r_state))
      w_fall_cnt_nxt = w_fall_fatal ? r_fall_cnt : r_fall_cnt + CNT_W'(1);
    if ((r_state == DIGL || r_state == DIGR) && (w_next == r_state))
      w_dig_cnt_nxt = (&r_dig_cnt) ? r_dig_cnt : r_dig_cnt + CNT_W'(1);
  end

  // State, counters and flags register together so outputs track the state exactly.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state    <= WL;
      r_fall_cnt <= '0;
      r_dig_cnt  <= '0;
      r_out      <= decode_state(WL);
    end else begin
      r_state    <= w_next;
      r_fall_cnt <= w_fall_cnt_nxt;
      r_dig_cnt  <= w_dig_cnt_nxt;
      r_out      <= decode_state(w_next);
    end
  end

  assign o_walk_left  = r_out.walk_left;
  assign o_walk_right = r_out.walk_right;
  assign o_aaah       = r_out.aaah;
  assign o_digging    = r_out.digging;
  assign o_blocking   = r_out.blocking;
  assign o_dead       = r_out.dead;

endmodule

// File: rtl/lemmings_array.sv
// N independent lemming channels plus an alive-count/all-dead summary for the scoreboard.
module lemmings_array
  import lemmings_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned FALL_LIMIT = 20,
  parameter int unsigned DIG_MAX    = 0
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic [N-1:0]             bump_left,
  input  logic [N-1:0]             bump_right,
  input  logic [N-1:0]             ground,
  input  logic [N-1:0]             dig,
  input  logic [N-1:0]             block,
  output logic [N-1:0]             walk_left,
  output logic [N-1:0]             walk_right,
  output logic [N-1:0]             aaah,
  output logic [N-1:0]             digging,
  output logic [N-1:0]             blocking,
  output logic [N-1:0]             dead,
  output logic [$clog2(N+1)-1:0]   alive_cnt,
  output logic                     all_dead
);

  localparam int unsigned AW = $clog2(N + 1);

  logic [AW-1:0] w_alive;

  for (genvar g = 0; g < N; g++) begin : g_chan
    lemming_fsm #(
      .FALL_LIMIT (FALL_LIMIT),
      .DIG_MAX    (DIG_MAX)
    ) u_fsm (
      .clk          (clk),
      .areset       (areset),
      .i_bump_left  (bump_left[g]),
      .i_bump_right (bump_right[g]),
      .i_ground     (ground[g]),
      .i_dig        (dig[g]),
      .i_block      (block[g]),
      .o_walk_left  (walk_left[g]),
      .o_walk_right (walk_right[g]),
      .o_aaah       (aaah[g]),
      .o_digging    (digging[g]),
      .o_blocking   (blocking[g]),
      .o_dead       (dead[g])
    );
  end

  // Popcount of live channels from the registered dead flags.
  always_comb begin
    w_alive = '0;
    for (int i = 0; i < N; i++) begin
      w_alive = w_alive + AW'(~dead[i]);
    end
  end

  assign alive_cnt = w_alive;
  assign all_dead  = (w_alive == '0);

endmodule

// File: tb/tb_lemmings_array.sv
// Scoreboard bench: two arrays (DIG_MAX=5 and DIG_MAX=0) share stimulus; a behavioural model predicts outputs.
module tb_lemmings_array;

  localparam int NCH = 4;
  localparam int FALL_LIM = 20;

  localparam int M_WALK  = 0;
  localparam int M_FALL  = 1;
  localparam int M_DIG   = 2;
  localparam int M_BLOCK = 3;
  localparam int M_DEAD  = 4;

  typedef struct packed {
    logic [3:0] wl;
    logic [3:0] wr;
    logic [3:0] fa;
    logic [3:0] dg;
    logic [3:0] bk;
    logic [3:0] dd;
    logic [2:0] alive;
    logic       all_dead;
  } obs_t;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic [3:0] bump_left = '0, bump_right = '0, ground = 4'hF, dig = '0, block = '0;

  logic [3:0] wl [2];
  logic [3:0] wr [2];
  logic [3:0] fa [2];
  logic [3:0] dg [2];
  logic [3:0] bk [2];
  logic [3:0] dd [2];
  logic [2:0] alive [2];
  logic       ad [2];

  int checks = 0;
  int errors = 0;

  // Model: per DUT, per channel activity, heading, and durations in cycles.
  int mode [2][NCH];
  int dirr [2][NCH];
  int fcyc [2][NCH];
  int dcyc [2][NCH];
  int dig_max [2] = '{5, 0};

  obs_t q0[$];
  obs_t q1[$];

  always #5 clk = ~clk;

  lemmings_array #(.N(NCH), .FALL_LIMIT(FALL_LIM), .DIG_MAX(5)) u_dut_d5 (
    .clk(clk), .areset(areset),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground), .dig(dig), .block(block),
    .walk_left(wl[0]), .walk_right(wr[0]), .aaah(fa[0]), .digging(dg[0]), .blocking(bk[0]),
    .dead(dd[0]), .alive_cnt(alive[0]), .all_dead(ad[0])
  );

  lemmings_array #(.N(NCH), .FALL_LIMIT(FALL_LIM), .DIG_MAX(0)) u_dut_d0 (
    .clk(clk), .areset(areset),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground), .dig(dig), .block(block),
    .walk_left(wl[1]), .walk_right(wr[1]), .aaah(fa[1]), .digging(dg[1]), .blocking(bk[1]),
    .dead(dd[1]), .alive_cnt(alive[1]), .all_dead(ad[1])
  );

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.wl = 4'hF;
    o.alive = 3'd4;
    return o;
  endfunction

  function automatic obs_t actual(input int d);
    obs_t o;
    o.wl = wl[d]; o.wr = wr[d]; o.fa = fa[d]; o.dg = dg[d]; o.bk = bk[d]; o.dd = dd[d];
    o.alive = alive[d]; o.all_dead = ad[d];
    return o;
  endfunction

  function automatic obs_t model_obs(input int d);
    obs_t o;
    int n;
    o = '0;
    n = 0;
    for (int c = 0; c < NCH; c++) begin
      o.wl[c] = (mode[d][c] == M_WALK) && (dirr[d][c] == 0);
      o.wr[c] = (mode[d][c] == M_WALK) && (dirr[d][c] == 1);
      o.fa[c] = (mode[d][c] == M_FALL);
      o.dg[c] = (mode[d][c] == M_DIG);
      o.bk[c] = (mode[d][c] == M_BLOCK);
      o.dd[c] = (mode[d][c] == M_DEAD);
      if (mode[d][c] != M_DEAD) n++;
    end
    o.alive = 3'(n);
    o.all_dead = (n == 0);
    return o;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        mode[d][c] = M_WALK; dirr[d][c] = 0; fcyc[d][c] = 0; dcyc[d][c] = 0;
      end
  endtask

  // fcyc/dcyc count output-visible cycles already spent falling/digging.
  task automatic model_step(input int d, input logic [3:0] bl, input logic [3:0] br,
                            input logic [3:0] g, input logic [3:0] dgc, input logic [3:0] bkc);
    for (int c = 0; c < NCH; c++) begin
      case (mode[d][c])
        M_WALK: begin
          if (!g[c]) begin mode[d][c] = M_FALL; fcyc[d][c] = 1; end
          else if (dgc[c]) begin mode[d][c] = M_DIG; dcyc[d][c] = 1; end
          else if (bkc[c]) mode[d][c] = M_BLOCK;
          else if ((dirr[d][c] == 0) ? bl[c] : br[c]) dirr[d][c] = 1 - dirr[d][c];
        end
        M_FALL: begin
          if (!g[c]) fcyc[d][c]++;
          else if (fcyc[d][c] > FALL_LIM) mode[d][c] = M_DEAD;
          else mode[d][c] = M_WALK;
        end
        M_DIG: begin
          if (!g[c]) begin mode[d][c] = M_FALL; fcyc[d][c] = 1; end
          else if (dig_max[d] != 0 && dcyc[d][c] == dig_max[d]) mode[d][c] = M_WALK;
          else dcyc[d][c]++;
        end
        M_BLOCK: if (!g[c]) begin mode[d][c] = M_FALL; fcyc[d][c] = 1; end
        default: ;
      endcase
    end
  endtask

  task automatic compare(input string nm, input int d, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got wl=%h wr=%h aaah=%h dig=%h blk=%h dead=%h alive=%0d all_dead=%b want wl=%h wr=%h aaah=%h dig=%h blk=%h dead=%h alive=%0d all_dead=%b",
               nm, d, $time, got.wl, got.wr, got.fa, got.dg, got.bk, got.dd, got.alive, got.all_dead,
               want.wl, want.wr, want.fa, want.dg, want.bk, want.dd, want.alive, want.all_dead);
    end
  endtask

  // Drive one cycle of inputs and queue the predicted post-edge outputs.
  task automatic step(input logic [3:0] bl, input logic [3:0] br, input logic [3:0] g,
                      input logic [3:0] dgc, input logic [3:0] bkc);
    @(negedge clk);
    areset = 1'b0;
    bump_left = bl; bump_right = br; ground = g; dig = dgc; block = bkc;
    model_step(0, bl, br, g, dgc, bkc);
    model_step(1, bl, br, g, dgc, bkc);
    q0.push_back(model_obs(0));
    q1.push_back(model_obs(1));
  endtask

  task automatic idle(input int n, input logic [3:0] g);
    for (int i = 0; i < n; i++) step(4'h0, 4'h0, g, 4'h0, 4'h0);
  endtask

  // Reset asserted mid-cycle must take effect before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    areset = 1'b1;
    #1;
    compare("async_reset", 0, actual(0), reset_obs());
    compare("async_reset", 1, actual(1), reset_obs());
    model_reset();
    q0.push_back(reset_obs());
    q1.push_back(reset_obs());
  endtask

  function automatic logic [3:0] rnd(input int one_in);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, one_in - 1) == 0);
    return v;
  endfunction

  // Monitor: one prediction per DUT per clock, compared just after the edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); compare("cycle", 0, actual(0), e); end
      if (q1.size() > 0) begin e = q1.pop_front(); compare("cycle", 1, actual(1), e); end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    model_reset();
    @(negedge clk);
    #1;
    compare("reset_state", 0, actual(0), reset_obs());
    compare("reset_state", 1, actual(1), reset_obs());

    idle(5, 4'hF);
    // ch0: turn right, fall 3 cycles, land walking right
    step(4'h1, 4'h0, 4'hF, 4'h0, 4'h0);
    idle(1, 4'hF);
    idle(3, 4'hE);
    idle(2, 4'hF);
    // ch1: 20-cycle fall survives, 21-cycle fall kills
    idle(20, 4'hD);
    idle(2, 4'hF);
    idle(21, 4'hD);
    idle(2, 4'hF);
    step(4'h2, 4'h2, 4'hF, 4'h2, 4'h2);
    step(4'h0, 4'h0, 4'hD, 4'h2, 4'h0);
    idle(3, 4'hD);
    idle(2, 4'hF);
    // ch2: dig pulse; limited vs unlimited digging, then ground loss
    step(4'h0, 4'h0, 4'hF, 4'h4, 4'h0);
    idle(100, 4'hF);
    idle(3, 4'hB);
    idle(2, 4'hF);
    // ch3: into WR, block beats bump, blocker ignores commands, falls right
    step(4'h8, 4'h0, 4'hF, 4'h0, 4'h0);
    step(4'h0, 4'h8, 4'hF, 4'h0, 4'h8);
    step(4'h0, 4'h8, 4'hF, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'hF, 4'h8, 4'h8);
    idle(2, 4'h7);
    idle(2, 4'hF);
    // reset mid-fall
    idle(5, 4'h0);
    do_reset();
    idle(3, 4'hF);
    // everyone falls 30 cycles and dies, then async reset revives
    idle(30, 4'h0);
    idle(3, 4'hF);
    do_reset();
    idle(2, 4'hF);

    // Randomized traffic with occasional long falls and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 149) == 0) begin
        logic [3:0] m;
        m = 4'h1 << $urandom_range(0, 3);
        idle($urandom_range(17, 24), ~m);
      end else begin
        step(rnd(4), rnd(4), ~rnd(10), rnd(16), rnd(32));
      end
    end

    w = 0;
    while ((q0.size() > 0 || q1.size() > 0) && w < 20) begin
      @(posedge clk);
      w++;
    end
    #2;
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending predictions want 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
